mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum number of ACCESS cycles without mem_ack before the access is aborted.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 WriteReg, MemToReg, Branch, ReadMem, WriteMem  input  1 each  control bits from the EX control pipeline register.
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 ALUResult  input  32  memory address / pass-through result.
REQ-007 WriteData  input  32  store data.
REQ-008 WriteAddr  input  5  destination register number.
REQ-009 mem_req  output  1  memory request, registered.
REQ-010 mem_we  output  1  1 = write, 0 = read, valid while mem_req is high.
REQ-011 mem_addr, mem_wdata  output  32 each  latched address and store data.
REQ-012 mem_rdata  input  32  load data, valid when mem_ack is high.
REQ-013 mem_ack  input  1  one-cycle completion strobe.
REQ-014 Stall  output  1  combinational; upstream holds its registers (En=0) while this is high.
REQ-015 PCSrc  output  1  combinational branch-taken signal.
REQ-016 BusErr  output  1  registered one-cycle pulse on timeout.
REQ-017 WriteReg_o, MemToReg_o  output  1 each  MEM/WB control register outputs.
REQ-018 ReadData_o, ALUResult_o  output  32 each  MEM/WB data register outputs.
REQ-019 WriteAddr_o  output  5  MEM/WB destination register output.

Function
REQ-020 The FSM SHALL have two states, IDLE and ACCESS; acc = ReadMem | WriteMem.
REQ-021 IDLE with acc=1: next state ACCESS; latch mem_addr=ALUResult, mem_wdata=WriteData, mem_we=WriteMem; capture WriteReg, MemToReg, WriteAddr and ALUResult into holding registers; clear cnt to 0.
REQ-022 ReadMem=WriteMem=1: treated as a write.
REQ-023 mem_req SHALL be 1 exactly while state = ACCESS.
REQ-024 ACCESS with mem_ack=1: next state IDLE; load MEM/WB from the holding registers, with ReadData_o = mem_rdata for reads and ReadData_o = 0 for writes.
REQ-025 ACCESS with mem_ack=0: cnt increments.
REQ-026 Timeout: ACCESS with mem_ack=0 and cnt = TIMEOUT-1 SHALL set BusErr=1 for the next cycle, go to IDLE and load MEM/WB with a bubble.
REQ-027 Stall = (IDLE & acc) | (ACCESS & ~mem_ack & ~timeout).
REQ-028 Minimum latency: 2 cycles per memory instruction (IDLE request cycle plus ACCESS cycle with ack).
REQ-029 IDLE with acc=0: MEM/WB loads the inputs directly each cycle, with ReadData_o = 0.
REQ-030 A bubble SHALL set WriteReg_o=0 and MemToReg_o=0, with data fields unchanged.
REQ-031 Any cycle with Stall=1 SHALL load a bubble into MEM/WB.
REQ-032 mem_ack in IDLE SHALL be ignored.
REQ-033 Inputs in ACCESS SHALL be ignored.
REQ-034 PCSrc = Branch & Zero & ~Stall.
REQ-035 cnt SHALL be wide enough for TIMEOUT, saturate, and never wrap while in ACCESS.

Reset
REQ-036 rst=1 at a clock edge SHALL force: state IDLE, cnt 0, mem_req/mem_we 0, mem_addr/mem_wdata 0, BusErr 0, and all MEM/WB outputs 0.
REQ-037 rst asserted mid-ACCESS: mem_req=0 from the next cycle; no MEM/WB load; a later ack SHALL be ignored.
REQ-038 Combinational outputs (Stall, PCSrc) SHALL follow their inputs during reset; rst has priority over every other event.

Verification
REQ-039 ALU op: WriteReg=1, WriteAddr=5, ALUResult=0x10, no access -> next cycle WriteReg_o=1, WriteAddr_o=5, ALUResult_o=0x10, Stall=0 throughout.
REQ-040 Load: ReadMem=1, ALUResult=0x40, ack on 3rd ACCESS cycle with rdata=0xDEADBEEF -> mem_req high 3 cycles, mem_addr=0x40, Stall high 3 cycles, then ReadData_o=0xDEADBEEF, MemToReg_o=1.
REQ-041 Store: WriteMem=1, WriteData=0x1234, immediate ack -> mem_we=1, mem_wdata=0x1234, one stall cycle, WriteReg_o=0.
REQ-042 Timeout: TIMEOUT=4, no ack -> mem_req high 4 cycles, BusErr pulses once, MEM/WB holds a bubble, Stall drops.
REQ-043 Reset mid-load, then ack 1 cycle later -> mem_req=0, all outputs 0, ack ignored, WriteReg_o stays 0.
REQ-044 Branch=1, Zero=1, no access -> PCSrc=1 in the same cycle; with Zero=0 -> PCSrc=0.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: two-state memory access FSM with a bounded wait, stall
// generation for upstream, and the MEM/WB pipeline register.
module mem_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WriteReg,
  input  logic        MemToReg,
  input  logic        Branch,
  input  logic        ReadMem,
  input  logic        WriteMem,
  input  logic        Zero,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [4:0]  WriteAddr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        Stall,
  output logic        PCSrc,
  output logic        BusErr,
  output logic        WriteReg_o,
  output logic        MemToReg_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALUResult_o,
  output logic [4:0]  WriteAddr_o
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt;
  logic            r_mem_req, r_mem_we, r_bus_err;
  logic [31:0]     r_mem_addr, r_mem_wdata;
  logic            r_hold_wr, r_hold_mtr;
  logic [4:0]      r_hold_waddr;
  logic [31:0]     r_hold_alu;
  logic            r_wb_wr, r_wb_mtr;
  logic [31:0]     r_wb_rdata, r_wb_alu;
  logic [4:0]      r_wb_waddr;

  logic w_acc, w_timeout, w_stall;

  assign w_acc     = ReadMem | WriteMem;
  assign w_timeout = (r_state == StAccess) & ~mem_ack & (r_cnt == CntLast);
  assign w_stall   = ((r_state == StIdle) & w_acc) |
                     ((r_state == StAccess) & ~mem_ack & ~w_timeout);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_acc) w_state_d = StAccess;
      StAccess: if (mem_ack || w_timeout) w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_bus_err    <= 1'b0;
      r_hold_wr    <= 1'b0;
      r_hold_mtr   <= 1'b0;
      r_hold_waddr <= '0;
      r_hold_alu   <= '0;
      r_wb_wr      <= 1'b0;
      r_wb_mtr     <= 1'b0;
      r_wb_rdata   <= '0;
      r_wb_alu     <= '0;
      r_wb_waddr   <= '0;
    end else begin
      r_state   <= w_state_d;
      r_bus_err <= w_timeout;
      // Bubble by default; only the non-stalled paths below overwrite MEM/WB.
      r_wb_wr   <= 1'b0;
      r_wb_mtr  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_acc) begin
            r_mem_req    <= 1'b1;
            r_mem_we     <= WriteMem;
            r_mem_addr   <= ALUResult;
            r_mem_wdata  <= WriteData;
            r_hold_wr    <= WriteReg;
            r_hold_mtr   <= MemToReg;
            r_hold_waddr <= WriteAddr;
            r_hold_alu   <= ALUResult;
            r_cnt        <= '0;
          end else begin
            r_wb_wr    <= WriteReg;
            r_wb_mtr   <= MemToReg;
            r_wb_rdata <= '0;
            r_wb_alu   <= ALUResult;
            r_wb_waddr <= WriteAddr;
          end
        end
        StAccess: begin
          if (mem_ack) begin
            r_mem_req  <= 1'b0;
            r_wb_wr    <= r_hold_wr;
            r_wb_mtr   <= r_hold_mtr;
            r_wb_rdata <= r_mem_we ? 32'h0 : mem_rdata;
            r_wb_alu   <= r_hold_alu;
            r_wb_waddr <= r_hold_waddr;
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
          end else if (r_cnt != {CntW{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign BusErr      = r_bus_err;
  assign Stall       = w_stall;
  assign PCSrc       = Branch & Zero & ~w_stall;
  assign WriteReg_o  = r_wb_wr;
  assign MemToReg_o  = r_wb_mtr;
  assign ReadData_o  = r_wb_rdata;
  assign ALUResult_o = r_wb_alu;
  assign WriteAddr_o = r_wb_waddr;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of pass-through vectors plus hand-written
// load, store, timeout and reset-mid-access sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        WriteReg, MemToReg, Branch, ReadMem, WriteMem, Zero;
  logic [31:0] ALUResult, WriteData, mem_rdata;
  logic [4:0]  WriteAddr;
  logic        mem_ack;
  logic        mem_req, mem_we, Stall, PCSrc, BusErr, WriteReg_o, MemToReg_o;
  logic [31:0] mem_addr, mem_wdata, ReadData_o, ALUResult_o;
  logic [4:0]  WriteAddr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .WriteReg(WriteReg), .MemToReg(MemToReg), .Branch(Branch),
    .ReadMem(ReadMem), .WriteMem(WriteMem), .Zero(Zero),
    .ALUResult(ALUResult), .WriteData(WriteData), .WriteAddr(WriteAddr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .Stall(Stall), .PCSrc(PCSrc), .BusErr(BusErr),
    .WriteReg_o(WriteReg_o), .MemToReg_o(MemToReg_o), .ReadData_o(ReadData_o),
    .ALUResult_o(ALUResult_o), .WriteAddr_o(WriteAddr_o)
  );

  typedef struct {
    logic        wr, mtr, br, zero, ack;
    logic [31:0] alu, wd, rdata;
    logic [4:0]  waddr;
    logic        exp_pcsrc, exp_wr, exp_mtr;
    logic [31:0] exp_alu;
    logic [4:0]  exp_waddr;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    WriteReg = 0; MemToReg = 0; Branch = 0; ReadMem = 0; WriteMem = 0; Zero = 0;
    ALUResult = '0; WriteData = '0; WriteAddr = '0; mem_ack = 0; mem_rdata = '0;
  endtask

  initial begin
    vecs[0] = '{wr:1, mtr:0, br:0, zero:0, ack:0, alu:32'h10, wd:32'h0, rdata:32'h0,
                waddr:5, exp_pcsrc:0, exp_wr:1, exp_mtr:0, exp_alu:32'h10, exp_waddr:5};
    vecs[1] = '{wr:0, mtr:0, br:1, zero:1, ack:0, alu:32'h20, wd:32'h0, rdata:32'h0,
                waddr:0, exp_pcsrc:1, exp_wr:0, exp_mtr:0, exp_alu:32'h20, exp_waddr:0};
    vecs[2] = '{wr:0, mtr:0, br:1, zero:0, ack:0, alu:32'h30, wd:32'h0, rdata:32'h0,
                waddr:1, exp_pcsrc:0, exp_wr:0, exp_mtr:0, exp_alu:32'h30, exp_waddr:1};
    vecs[3] = '{wr:1, mtr:1, br:0, zero:0, ack:1, alu:32'hFFFF_FFFF, wd:32'h9,
                rdata:32'h55, waddr:31, exp_pcsrc:0, exp_wr:1, exp_mtr:1,
                exp_alu:32'hFFFF_FFFF, exp_waddr:31};
    vecs[4] = '{wr:1, mtr:0, br:0, zero:1, ack:0, alu:32'hA5A5_0000, wd:32'h0,
                rdata:32'h0, waddr:12, exp_pcsrc:0, exp_wr:1, exp_mtr:0,
                exp_alu:32'hA5A5_0000, exp_waddr:12};

    // Reset
    clear_inputs();
    rst = 1;
    tick();
    tick();
    check("rst mem_req", 32'(mem_req), 0);
    check("rst mem_we", 32'(mem_we), 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst BusErr", 32'(BusErr), 0);
    check("rst WriteReg_o", 32'(WriteReg_o), 0);
    check("rst MemToReg_o", 32'(MemToReg_o), 0);
    check("rst ReadData_o", ReadData_o, 0);
    check("rst ALUResult_o", ALUResult_o, 0);
    check("rst WriteAddr_o", 32'(WriteAddr_o), 0);
    ReadMem = 1; #1;
    check("rst Stall follows input", 32'(Stall), 1);
    ReadMem = 0; #1;
    rst = 0;

    // Pass-through vectors (no memory access; mem_ack in IDLE is ignored)
    for (int i = 0; i < 5; i++) begin
      WriteReg = vecs[i].wr; MemToReg = vecs[i].mtr; Branch = vecs[i].br;
      Zero = vecs[i].zero; mem_ack = vecs[i].ack; ALUResult = vecs[i].alu;
      WriteData = vecs[i].wd; mem_rdata = vecs[i].rdata; WriteAddr = vecs[i].waddr;
      #1;
      check($sformatf("v%0d Stall", i), 32'(Stall), 0);
      check($sformatf("v%0d PCSrc", i), 32'(PCSrc), 32'(vecs[i].exp_pcsrc));
      tick();
      check($sformatf("v%0d mem_req", i), 32'(mem_req), 0);
      check($sformatf("v%0d WriteReg_o", i), 32'(WriteReg_o), 32'(vecs[i].exp_wr));
      check($sformatf("v%0d MemToReg_o", i), 32'(MemToReg_o), 32'(vecs[i].exp_mtr));
      check($sformatf("v%0d ALUResult_o", i), ALUResult_o, vecs[i].exp_alu);
      check($sformatf("v%0d WriteAddr_o", i), 32'(WriteAddr_o), 32'(vecs[i].exp_waddr));
      check($sformatf("v%0d ReadData_o", i), ReadData_o, 0);
    end
    clear_inputs();

    // Load with ack on the third ACCESS cycle
    ReadMem = 1; WriteReg = 1; MemToReg = 1; WriteAddr = 7; ALUResult = 32'h40;
    Branch = 1; Zero = 1; #1;
    check("ld req Stall", 32'(Stall), 1);
    check("ld req PCSrc masked", 32'(PCSrc), 0);
    check("ld req mem_req", 32'(mem_req), 0);
    tick();
    clear_inputs();
    ALUResult = 32'h999; WriteAddr = 2;
    for (int k = 0; k < 3; k++) begin
      mem_ack = (k == 2); mem_rdata = 32'hDEAD_BEEF; #1;
      check($sformatf("ld a%0d mem_req", k), 32'(mem_req), 1);
      check($sformatf("ld a%0d mem_addr", k), mem_addr, 32'h40);
      check($sformatf("ld a%0d mem_we", k), 32'(mem_we), 0);
      check($sformatf("ld a%0d Stall", k), 32'(Stall), (k < 2) ? 1 : 0);
      check($sformatf("ld a%0d WriteReg_o bubble", k), 32'(WriteReg_o), 0);
      tick();
    end
    clear_inputs();
    check("ld done mem_req", 32'(mem_req), 0);
    check("ld ReadData_o", ReadData_o, 32'hDEAD_BEEF);
    check("ld MemToReg_o", 32'(MemToReg_o), 1);
    check("ld WriteReg_o", 32'(WriteReg_o), 1);
    check("ld ALUResult_o", ALUResult_o, 32'h40);
    check("ld WriteAddr_o", 32'(WriteAddr_o), 7);

    // Store (ReadMem and WriteMem both set: write wins), immediate ack
    WriteMem = 1; ReadMem = 1; MemToReg = 1; WriteData = 32'h1234; ALUResult = 32'h80;
    WriteAddr = 3; #1;
    check("st req Stall", 32'(Stall), 1);
    tick();
    clear_inputs();
    mem_ack = 1; mem_rdata = 32'hAAAA_AAAA; #1;
    check("st mem_req", 32'(mem_req), 1);
    check("st mem_we", 32'(mem_we), 1);
    check("st mem_wdata", mem_wdata, 32'h1234);
    check("st mem_addr", mem_addr, 32'h80);
    check("st ack Stall", 32'(Stall), 0);
    tick();
    mem_ack = 0;
    check("st done mem_req", 32'(mem_req), 0);
    check("st WriteReg_o", 32'(WriteReg_o), 0);
    check("st ReadData_o", ReadData_o, 0);
    check("st ALUResult_o", ALUResult_o, 32'h80);
    check("st WriteAddr_o", 32'(WriteAddr_o), 3);

    // Timeout with TIMEOUT=4: request cycle loads a bubble, data fields held
    ReadMem = 1; WriteReg = 1; MemToReg = 1; WriteAddr = 9; ALUResult = 32'h100;
    tick();
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("to a%0d mem_req", k), 32'(mem_req), 1);
      check($sformatf("to a%0d Stall", k), 32'(Stall), (k < 3) ? 1 : 0);
      check($sformatf("to a%0d BusErr", k), 32'(BusErr), 0);
      tick();
    end
    check("to mem_req dropped", 32'(mem_req), 0);
    check("to BusErr pulse", 32'(BusErr), 1);
    check("to WriteReg_o bubble", 32'(WriteReg_o), 0);
    check("to MemToReg_o bubble", 32'(MemToReg_o), 0);
    check("to ALUResult_o held", ALUResult_o, 32'h80);
    check("to WriteAddr_o held", 32'(WriteAddr_o), 3);
    check("to Stall idle", 32'(Stall), 0);
    tick();
    check("to BusErr single", 32'(BusErr), 0);

    // Reset mid-load, then a late ack
    ReadMem = 1; WriteReg = 1; MemToReg = 1; WriteAddr = 4; ALUResult = 32'h200;
    tick();
    clear_inputs();
    check("rl mem_req before rst", 32'(mem_req), 1);
    rst = 1;
    tick();
    rst = 0;
    mem_ack = 1; mem_rdata = 32'h77; #1;
    check("rl mem_req", 32'(mem_req), 0);
    check("rl mem_addr", mem_addr, 0);
    check("rl WriteReg_o", 32'(WriteReg_o), 0);
    check("rl ALUResult_o", ALUResult_o, 0);
    check("rl Stall", 32'(Stall), 0);
    tick();
    mem_ack = 0;
    check("rl late ack mem_req", 32'(mem_req), 0);
    check("rl late ack WriteReg_o", 32'(WriteReg_o), 0);
    check("rl late ack ReadData_o", ReadData_o, 0);
    check("rl late ack BusErr", 32'(BusErr), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
